// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, control-bundle bit positions and bubble
// constants for the MIPS pipeline registers.
//   CTLWB  = {regwrite, memtoreg}
//   CTLM   = {branch, memread, memwrite}
//   CTLEX  = {regdst, aluop[1:0], alusrc}
package mips_pkg;
    localparam int CTLWB_W      = 2;
    localparam int CTLM_W       = 3;
    localparam int CTLEX_W      = 4;
    localparam int MEMREAD_BIT  = 1;
    localparam int REGWRITE_BIT = 1;

    localparam logic [CTLWB_W-1:0] CTLWB_BUBBLE = '0;
    localparam logic [CTLM_W-1:0]  CTLM_BUBBLE  = '0;
    localparam logic [CTLEX_W-1:0] CTLEX_BUBBLE = '0;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: W-bit pipeline field register.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears to 0
//   hold   - keep current value
//   bubble - clear to 0 (bubble value for every id_ex field)
//   d / q  - load data / registered value
// Priority on each edge: rst > hold > bubble > load.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)         q <= '0;
        else if (hold)   q <= q;
        else if (bubble) q <= '0;
        else             q <= d;
    end
endmodule

// File: rtl/id_ex_latch.sv
// id_ex_latch: ID/EX pipeline register of the 5-stage MIPS core.
// Captures register-file A/B, sign-extended immediate, rs/rt/rd and the
// WB/M/EX control bundles; supports stall (hold), flush (bubble) and a
// self-inserted load-use bubble, and flags the load-use hazard upstream.
// Ports:
//   clk, rst (sync, active high), stall, flush
//   ctlwb_in[2], ctlm_in[3], ctlex_in[4], npc_in, readdat1, readdat2,
//   signext_in, rs_in, rt_in, rd_in            - ID-stage inputs
//   wb_regwrite, wb_rd, wb_writedata           - WB write port (bypass)
//   ctlwb_out, ctlm_out, ctlex_out, npc_out, readdat1_out, readdat2_out,
//   signext_out, rs_out, rt_out, rd_out        - registered outputs
//   valid_out    - 1 real instruction, 0 bubble
//   hazard_stall - combinational load-use hazard flag
// Configuration macro: ID_EX_WB_BYPASS_EN enables WB->ID write-data bypass
// on A/B capture (covers register-file read-during-write).
module id_ex_latch
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic [CTLWB_W-1:0]        ctlwb_in,
    input  logic [CTLM_W-1:0]         ctlm_in,
    input  logic [CTLEX_W-1:0]        ctlex_in,
    input  logic [DATA_WIDTH-1:0]     npc_in,
    input  logic [DATA_WIDTH-1:0]     readdat1,
    input  logic [DATA_WIDTH-1:0]     readdat2,
    input  logic [DATA_WIDTH-1:0]     signext_in,
    input  logic [REG_ADDR_WIDTH-1:0] rs_in,
    input  logic [REG_ADDR_WIDTH-1:0] rt_in,
    input  logic [REG_ADDR_WIDTH-1:0] rd_in,
    input  logic                      wb_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_writedata,
    output logic [CTLWB_W-1:0]        ctlwb_out,
    output logic [CTLM_W-1:0]         ctlm_out,
    output logic [CTLEX_W-1:0]        ctlex_out,
    output logic [DATA_WIDTH-1:0]     npc_out,
    output logic [DATA_WIDTH-1:0]     readdat1_out,
    output logic [DATA_WIDTH-1:0]     readdat2_out,
    output logic [DATA_WIDTH-1:0]     signext_out,
    output logic [REG_ADDR_WIDTH-1:0] rs_out,
    output logic [REG_ADDR_WIDTH-1:0] rt_out,
    output logic [REG_ADDR_WIDTH-1:0] rd_out,
    output logic                      valid_out,
    output logic                      hazard_stall
);
    localparam int RAW = REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] a_d, b_d;
    logic                  bubble;

    // Hazard is taken from registered state: once the bubble is inserted
    // the load leaves this stage and the flag drops by itself.
    assign hazard_stall = valid_out && ctlm_out[MEMREAD_BIT] && (rt_out != '0)
                          && ((rt_out == rs_in) || (rt_out == rt_in));

    assign bubble = flush | hazard_stall;

`ifdef ID_EX_WB_BYPASS_EN
    // WB write lands in the register file on the same edge we capture, so
    // forward it here; $0 is never a bypass source.
    logic wb_hit;
    assign wb_hit = wb_regwrite && (wb_rd != '0);
    assign a_d = (wb_hit && (wb_rd == rs_in)) ? wb_writedata : readdat1;
    assign b_d = (wb_hit && (wb_rd == rt_in)) ? wb_writedata : readdat2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_regwrite, wb_rd, wb_writedata};
    assign a_d = readdat1;
    assign b_d = readdat2;
`endif

    pipe_reg #(.W(CTLWB_W)) u_ctlwb (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                     .d(ctlwb_in), .q(ctlwb_out));
    pipe_reg #(.W(CTLM_W))  u_ctlm  (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                     .d(ctlm_in), .q(ctlm_out));
    pipe_reg #(.W(CTLEX_W)) u_ctlex (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                     .d(ctlex_in), .q(ctlex_out));
    pipe_reg #(.W(DATA_WIDTH)) u_npc (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                      .d(npc_in), .q(npc_out));
    pipe_reg #(.W(DATA_WIDTH)) u_a   (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                      .d(a_d), .q(readdat1_out));
    pipe_reg #(.W(DATA_WIDTH)) u_b   (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                      .d(b_d), .q(readdat2_out));
    pipe_reg #(.W(DATA_WIDTH)) u_imm (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                      .d(signext_in), .q(signext_out));
    pipe_reg #(.W(3*RAW)) u_regs (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                                  .d({rs_in, rt_in, rd_in}), .q({rs_out, rt_out, rd_out}));
    pipe_reg #(.W(1)) u_valid (.clk(clk), .rst(rst), .hold(stall), .bubble(bubble),
                               .d(1'b1), .q(valid_out));
endmodule

// File: tb/tb_id_ex_latch.sv
// tb_id_ex_latch: directed self-checking bench for id_ex_latch.
module tb_id_ex_latch;
    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [1:0]  ctlwb_in;
    logic [2:0]  ctlm_in;
    logic [3:0]  ctlex_in;
    logic [31:0] npc_in, readdat1, readdat2, signext_in, wb_writedata;
    logic [4:0]  rs_in, rt_in, rd_in, wb_rd;
    logic        wb_regwrite;
    logic [1:0]  ctlwb_out;
    logic [2:0]  ctlm_out;
    logic [3:0]  ctlex_out;
    logic [31:0] npc_out, readdat1_out, readdat2_out, signext_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        valid_out, hazard_stall;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_ex_latch dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in), .ctlex_in(ctlex_in),
        .npc_in(npc_in), .readdat1(readdat1), .readdat2(readdat2),
        .signext_in(signext_in), .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_writedata(wb_writedata),
        .ctlwb_out(ctlwb_out), .ctlm_out(ctlm_out), .ctlex_out(ctlex_out),
        .npc_out(npc_out), .readdat1_out(readdat1_out), .readdat2_out(readdat2_out),
        .signext_out(signext_out), .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .valid_out(valid_out), .hazard_stall(hazard_stall)
    );

    // Advance one edge; outputs are stable 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0;
        ctlwb_in = 0; ctlm_in = 0; ctlex_in = 0;
        npc_in = 0; readdat1 = 0; readdat2 = 0; signext_in = 0;
        rs_in = 0; rt_in = 0; rd_in = 0;
        wb_regwrite = 0; wb_rd = 0; wb_writedata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        ctlwb_in = 2'b11; ctlm_in = 3'b111; ctlex_in = 4'hF;
        npc_in = 32'h1234; readdat1 = 32'hAAAA; readdat2 = 32'hBBBB;
        rs_in = 7; rt_in = 8; rd_in = 9;
        rst = 1;
        step();
        vectors++;
        if ({ctlwb_out, ctlm_out, ctlex_out} !== 9'd0) begin
            miscompares++; $display("FAIL reset_ctl got %h want 0", {ctlwb_out, ctlm_out, ctlex_out});
        end
        vectors++;
        if ({npc_out, readdat1_out, readdat2_out, signext_out} !== 128'd0) begin
            miscompares++; $display("FAIL reset_data got %h want 0", {npc_out, readdat1_out, readdat2_out, signext_out});
        end
        vectors++;
        if ({rs_out, rt_out, rd_out, valid_out, hazard_stall} !== 17'd0) begin
            miscompares++; $display("FAIL reset_addr_valid got %h want 0", {rs_out, rt_out, rd_out, valid_out, hazard_stall});
        end
        rst = 0;
    endtask

    task automatic test_load();
        idle_inputs();
        readdat1 = 32'h4; rs_in = 2; ctlm_in = 3'b000;
        ctlwb_in = 2'b10; ctlex_in = 4'b1010; npc_in = 32'h8;
        readdat2 = 32'h7; signext_in = 32'hFFFF_FFF0; rt_in = 5; rd_in = 6;
        step();
        vectors++;
        if (readdat1_out !== 32'h4 || rs_out !== 5'd2 || valid_out !== 1'b1) begin
            miscompares++; $display("FAIL load_basic got a=%h rs=%0d v=%b want a=4 rs=2 v=1", readdat1_out, rs_out, valid_out);
        end
        vectors++;
        if (ctlwb_out !== 2'b10 || ctlex_out !== 4'b1010 || npc_out !== 32'h8 || readdat2_out !== 32'h7
            || signext_out !== 32'hFFFF_FFF0 || rt_out !== 5'd5 || rd_out !== 5'd6 || ctlm_out !== 3'b000) begin
            miscompares++; $display("FAIL load_fields got wb=%b ex=%b npc=%h b=%h imm=%h rt=%0d rd=%0d", ctlwb_out, ctlex_out, npc_out, readdat2_out, signext_out, rt_out, rd_out);
        end
        vectors++;
        if (hazard_stall !== 1'b0) begin
            miscompares++; $display("FAIL load_no_hazard got %b want 0", hazard_stall);
        end
    endtask

    task automatic test_stall();
        // State from test_load is held while inputs churn.
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            readdat1 = 32'h100 + i; rs_in = 5'(10 + i); ctlwb_in = 2'b01; npc_in = 32'h40 + i;
            flush = (i == 1);
            step();
            vectors++;
            if (readdat1_out !== 32'h4 || rs_out !== 5'd2 || ctlwb_out !== 2'b10 || npc_out !== 32'h8 || valid_out !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold[%0d] got a=%h rs=%0d wb=%b npc=%h v=%b", i, readdat1_out, rs_out, ctlwb_out, npc_out, valid_out);
            end
        end
        stall = 0; flush = 0;
        step();
        vectors++;
        if (readdat1_out !== 32'h102 || rs_out !== 5'd12 || npc_out !== 32'h42) begin
            miscompares++; $display("FAIL stall_release got a=%h rs=%0d npc=%h want 102/12/42", readdat1_out, rs_out, npc_out);
        end
    endtask

    task automatic test_hazard();
        idle_inputs();
        ctlm_in = 3'b010; rt_in = 3; rs_in = 1; rd_in = 0; ctlwb_in = 2'b11;
        step();
        ctlm_in = 3'b000; ctlwb_in = 2'b10; rs_in = 3; rt_in = 4;
        #1;
        vectors++;
        if (hazard_stall !== 1'b1) begin
            miscompares++; $display("FAIL hazard_rs got %b want 1", hazard_stall);
        end
        step();
        vectors++;
        if (valid_out !== 1'b0 || ctlm_out !== 3'b000 || ctlwb_out !== 2'b00 || hazard_stall !== 1'b0) begin
            miscompares++; $display("FAIL hazard_bubble got v=%b m=%b wb=%b hz=%b want 0", valid_out, ctlm_out, ctlwb_out, hazard_stall);
        end
        step();
        vectors++;
        if (valid_out !== 1'b1 || rs_out !== 5'd3) begin
            miscompares++; $display("FAIL hazard_reissue got v=%b rs=%0d want 1/3", valid_out, rs_out);
        end
        // Load again; rt match, and hold through a stall.
        ctlm_in = 3'b010; rt_in = 6; rs_in = 0;
        step();
        ctlm_in = 3'b000; rs_in = 1; rt_in = 6; stall = 1;
        step();
        vectors++;
        if (hazard_stall !== 1'b1 || valid_out !== 1'b1 || ctlm_out !== 3'b010) begin
            miscompares++; $display("FAIL hazard_stall_hold got hz=%b v=%b m=%b want 1/1/010", hazard_stall, valid_out, ctlm_out);
        end
        stall = 0;
        step();
        vectors++;
        if (hazard_stall !== 1'b0 || valid_out !== 1'b0) begin
            miscompares++; $display("FAIL hazard_after_stall got hz=%b v=%b want 0/0", hazard_stall, valid_out);
        end
        // Load into $0 never flags a hazard.
        ctlm_in = 3'b010; rt_in = 0; rs_in = 0;
        step();
        ctlm_in = 3'b000;
        #1;
        vectors++;
        if (hazard_stall !== 1'b0 || valid_out !== 1'b1) begin
            miscompares++; $display("FAIL hazard_r0 got hz=%b v=%b want 0/1", hazard_stall, valid_out);
        end
        step();
    endtask

    task automatic test_flush();
        idle_inputs();
        ctlwb_in = 2'b10; ctlex_in = 4'b0110; ctlm_in = 3'b001; rs_in = 4; rt_in = 5; readdat1 = 32'h55;
        flush = 1;
        step();
        vectors++;
        if ({ctlwb_out, ctlm_out, ctlex_out} !== 9'd0 || valid_out !== 1'b0 || readdat1_out !== 32'd0 || rs_out !== 5'd0) begin
            miscompares++; $display("FAIL flush_bubble got ctl=%h v=%b a=%h rs=%0d want 0", {ctlwb_out, ctlm_out, ctlex_out}, valid_out, readdat1_out, rs_out);
        end
        flush = 0;
        step();
        flush = 1; stall = 1; ctlwb_in = 2'b01;
        step();
        vectors++;
        if (valid_out !== 1'b1 || ctlwb_out !== 2'b10 || ctlex_out !== 4'b0110 || readdat1_out !== 32'h55) begin
            miscompares++; $display("FAIL flush_stall_hold got v=%b wb=%b ex=%b a=%h want 1/10/0110/55", valid_out, ctlwb_out, ctlex_out, readdat1_out);
        end
        // Reset wins over stall.
        rst = 1;
        step();
        vectors++;
        if (valid_out !== 1'b0 || ctlex_out !== 4'd0 || readdat1_out !== 32'd0) begin
            miscompares++; $display("FAIL reset_mid_stall got v=%b ex=%b a=%h want 0", valid_out, ctlex_out, readdat1_out);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_b, exp_a;
        idle_inputs();
        wb_regwrite = 1; wb_rd = 3; wb_writedata = 32'h100;
        rt_in = 3; readdat2 = 32'h0; rs_in = 5; readdat1 = 32'h55;
`ifdef ID_EX_WB_BYPASS_EN
        exp_b = 32'h100;
`else
        exp_b = 32'h0;
`endif
        step();
        vectors++;
        if (readdat2_out !== exp_b || readdat1_out !== 32'h55) begin
            miscompares++; $display("FAIL bypass_rt got b=%h a=%h want b=%h a=55", readdat2_out, readdat1_out, exp_b);
        end
        wb_rd = 5; wb_writedata = 32'h200; rs_in = 5; readdat1 = 32'h11; rt_in = 6; readdat2 = 32'h66;
`ifdef ID_EX_WB_BYPASS_EN
        exp_a = 32'h200;
`else
        exp_a = 32'h11;
`endif
        step();
        vectors++;
        if (readdat1_out !== exp_a || readdat2_out !== 32'h66) begin
            miscompares++; $display("FAIL bypass_rs got a=%h b=%h want a=%h b=66", readdat1_out, readdat2_out, exp_a);
        end
        wb_rd = 0; wb_writedata = 32'h300; rs_in = 0; rt_in = 0; readdat1 = 32'h0; readdat2 = 32'h22;
        step();
        vectors++;
        if (readdat1_out !== 32'h0 || readdat2_out !== 32'h22) begin
            miscompares++; $display("FAIL bypass_r0 got a=%h b=%h want 0/22", readdat1_out, readdat2_out);
        end
        wb_regwrite = 0; wb_rd = 3; rt_in = 3; readdat2 = 32'h33;
        step();
        vectors++;
        if (readdat2_out !== 32'h33) begin
            miscompares++; $display("FAIL bypass_nowrite got b=%h want 33", readdat2_out);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #2;
        test_reset();
        test_load();
        test_stall();
        test_hazard();
        test_flush();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
